dispatch_ctrl: RTL

DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

---
 rtl/dispatch_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: 4-phase dispatcher from the decode stage to the
// branch/jump, load/store and ALU units, with ack timeout and a sticky error.
module dispatch_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        req_in,
    output logic        ack_out,
    output logic        req_out_1,
    output logic        req_out_2,
    output logic        req_out_3,
    input  logic        ack_1,
    input  logic        ack_2,
    input  logic        ack_3,
    output logic        busy,
    output logic [1:0]  unit_sel,
    output logic        err,
    input  logic        err_clr,
    output logic [15:0] dispatch_cnt
);

    typedef enum logic [2:0] {IDLE, ISSUE, RELEASE, DONE, ERR} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] req_sync, ack1_sync, ack2_sync, ack3_sync;
    logic                   req_s, ack1_s, ack2_s, ack3_s;
    logic [1:0]             op_class;
    logic [2:0]             op_req;
    logic                   ack_sel;
    logic [2:0]             req_q, req_n;
    logic                   ack_n;
    logic [1:0]             sel_n;
    logic                   err_set;
    logic                   cnt_inc;
    logic [15:0]            tmo_cnt, tmo_n;

    assign req_s  = req_sync[SYNC_STAGES-1];
    assign ack1_s = ack1_sync[SYNC_STAGES-1];
    assign ack2_s = ack2_sync[SYNC_STAGES-1];
    assign ack3_s = ack3_sync[SYNC_STAGES-1];

    assign req_out_1 = req_q[0];
    assign req_out_2 = req_q[1];
    assign req_out_3 = req_q[2];
    assign busy      = (state != IDLE);

    // Multi-flop synchronizers for the asynchronous request and acknowledges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_sync  <= '0;
            ack1_sync <= '0;
            ack2_sync <= '0;
            ack3_sync <= '0;
        end else begin
            req_sync  <= {req_sync[SYNC_STAGES-2:0], req_in};
            ack1_sync <= {ack1_sync[SYNC_STAGES-2:0], ack_1};
            ack2_sync <= {ack2_sync[SYNC_STAGES-2:0], ack_2};
            ack3_sync <= {ack3_sync[SYNC_STAGES-2:0], ack_3};
        end
    end

    // Opcode class decode and the matching one-hot unit request
    always_comb begin
        op_class = 2'd0;
        op_req   = 3'b000;
        case (opcode)
            7'b1100011, 7'b1101111: begin
                op_class = 2'd1;
                op_req   = 3'b001;
            end
            7'b0000011, 7'b0100011: begin
                op_class = 2'd2;
                op_req   = 3'b010;
            end
            7'b0110011, 7'b0010011, 7'b0000000: begin
                op_class = 2'd3;
                op_req   = 3'b100;
            end
            default: begin
                op_class = 2'd0;
                op_req   = 3'b000;
            end
        endcase
    end

    // Only the latched unit's acknowledge is observed
    always_comb begin
        case (unit_sel)
            2'd1:    ack_sel = ack1_s;
            2'd2:    ack_sel = ack2_s;
            2'd3:    ack_sel = ack3_s;
            default: ack_sel = 1'b0;
        endcase
    end

    // Next-state and next registered-output logic
    always_comb begin
        state_n = state;
        req_n   = req_q;
        ack_n   = ack_out;
        sel_n   = unit_sel;
        err_set = 1'b0;
        cnt_inc = 1'b0;
        tmo_n   = tmo_cnt;
        case (state)
            IDLE: begin
                if (req_s) begin
                    if (op_class != 2'd0) begin
                        state_n = ISSUE;
                        sel_n   = op_class;
                        req_n   = op_req;
                        tmo_n   = '0;
                    end else begin
                        state_n = ERR;
                        sel_n   = 2'd0;
                        err_set = 1'b1;
                        ack_n   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (ack_sel) begin
                    state_n = RELEASE;
                    req_n   = 3'b000;
                    tmo_n   = '0;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_n = ERR;
                    req_n   = 3'b000;
                    err_set = 1'b1;
                    ack_n   = 1'b1;
                end else begin
                    tmo_n = tmo_cnt + 16'd1;
                end
            end
            RELEASE: begin
                if (!ack_sel) begin
                    state_n = DONE;
                    ack_n   = 1'b1;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_n = ERR;
                    req_n   = 3'b000;
                    err_set = 1'b1;
                    ack_n   = 1'b1;
                end else begin
                    tmo_n = tmo_cnt + 16'd1;
                end
            end
            DONE: begin
                if (!req_s) begin
                    state_n = IDLE;
                    ack_n   = 1'b0;
                    cnt_inc = 1'b1;
                end
            end
            ERR: begin
                if (!req_s) begin
                    state_n = IDLE;
                    ack_n   = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                req_n   = 3'b000;
                ack_n   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; an error set wins over err_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            req_q        <= '0;
            ack_out      <= 1'b0;
            unit_sel     <= '0;
            err          <= 1'b0;
            dispatch_cnt <= '0;
            tmo_cnt      <= '0;
        end else begin
            state        <= state_n;
            req_q        <= req_n;
            ack_out      <= ack_n;
            unit_sel     <= sel_n;
            tmo_cnt      <= tmo_n;
            dispatch_cnt <= dispatch_cnt + {15'd0, cnt_inc};
            if (err_set)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
        end
    end

endmodule
